mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have derived parameter CNT_W, default $clog2(WIDTH)+1, step-counter width; not overridden.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (RV M semantics).
REQ-008 SHALL have ports a, b  input  WIDTH  operands (a = rs1/dividend, b = rs2/divisor).
REQ-009 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-010 SHALL have port out_valid  output  1  result held.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  WIDTH  operation result.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Accept = in_valid & in_ready at a rising edge; SHALL register op, a, b and operand signs at that edge.
REQ-015 Normal path: IDLE->BUSY on accept, counter loaded with WIDTH; one shift-add (mul) or restoring-subtract (div) step per BUSY edge, counter decrements.
REQ-016 BUSY->DONE on the edge performing the last step; out_valid first high exactly WIDTH cycles after the accept edge.
REQ-017 Signed ops SHALL compute on magnitudes and negate the result by sign: MUL*/MULHSU use a sign (a only for MULHSU), DIV quotient sign a^b, REM remainder takes the sign of a.
REQ-018 MUL returns product[WIDTH-1:0]; MULH/MULHSU/MULHU return product[2*WIDTH-1:WIDTH] of the 2*WIDTH-bit product.
REQ-019 Divide by zero (b==0, op 4-7): SHALL skip BUSY and go IDLE->DONE; DIV/DIVU = all ones, REM/REMU = a; out_valid 1 cycle after accept.
REQ-020 Signed overflow (DIV/REM, a==MIN, b==all ones): SHALL go IDLE->DONE; DIV = MIN, REM = 0; latency 1.
REQ-021 DONE holds result and out_valid stable until out_ready; DONE->IDLE on out_valid & out_ready; in_ready high the following cycle (no same-cycle reaccept).
REQ-022 flush SHALL force state IDLE at the next edge from any state, discarding the result; flush beats in_valid in the same cycle (no accept).
REQ-023 result SHALL be 0 whenever out_valid is low.
REQ-024 Inputs a, b, op SHALL be ignored outside the accept edge; changes during BUSY do not affect the result.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, internal datapath regs 0; in_ready=1, out_valid=0, result=0.
REQ-026 Reset mid-BUSY or in DONE SHALL drop the operation with no output; first accept is possible at the first edge after rst_n deasserts.

Configuration
REQ-027 Macro MDU_ITER_DIV_EN defined: divider datapath compiled in; ops 4-7 behave per REQ-015..REQ-020.
REQ-028 MDU_ITER_DIV_EN undefined: no divider logic; ops 4-7 go IDLE->DONE in 1 cycle with result all ones; ops 0-3 unchanged.

Verification
REQ-029 WIDTH=32, MUL a=0xFFFFFFFF b=0x00000002 -> out_valid 32 cycles after accept, result=0xFFFFFFFE; MULHU same operands -> 0x00000001; MULH same operands -> 0xFFFFFFFF.
REQ-030 DIV a=0xFFFFFFF9(-7) b=2 -> 0xFFFFFFFD(-3); REM same operands -> 0xFFFFFFFF(-1); DIVU 100/7 -> 14, REMU -> 2.
REQ-031 DIVU a=0x12345678 b=0 -> result 0xFFFFFFFF, out_valid 1 cycle after accept; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 out_ready held low 5 cycles in DONE -> result stable, in_ready=0 throughout; out_ready high -> in_ready=1 next cycle.
REQ-033 flush asserted 10 cycles into BUSY with in_valid=1 -> no out_valid, IDLE next edge, no accept that cycle; rst_n pulsed mid-BUSY -> out_valid=0, in_ready=1 immediately.
REQ-034 Build without MDU_ITER_DIV_EN: DIV 100/7 -> 0xFFFFFFFF after 1 cycle; MUL 3*5 -> 15 after 32 cycles.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M/RV64M-style multiply/divide unit.
//   Multiplication is shift-add and division is restoring. Both run one step per cycle
//   on operand magnitudes, and the result is negated by sign at the output.
//   Divide-by-zero and signed overflow bypass the iteration and complete at the accept edge.
//
// Build option: define MDU_ITER_DIV_EN to compile in the divider datapath.
//   Without it, ops 4-7 finish at the accept edge with an all-ones result.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake; in_ready is high only in IDLE
//   op                   0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   a, b                 rs1 (dividend) and rs2 (divisor), sampled only at accept
//   flush                synchronous abort, returns to IDLE and drops any result
//   out_valid/out_ready  result handshake; result is held until taken
//   result               operation result, forced to 0 while out_valid is low
module mdu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpRem    = 3'd6;

  localparam logic [WIDTH-1:0] AllOnes = '1;
  localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] opnd_q;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q;    // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;    // multiplier -> product low half / dividend -> quotient
  logic             neg_q;   // negate the selected result

  logic             accept;
  logic             fast;    // complete at the accept edge without iterating
  logic             sign_a, sign_b, neg_d;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign accept = in_valid & in_ready & ~flush;

  // Operand signs: only the signed operands of each op contribute.
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (op)
      OpMul, OpMulh, OpDiv, OpRem: begin
        sign_a = a[WIDTH-1];
        sign_b = b[WIDTH-1];
      end
      OpMulhsu: sign_a = a[WIDTH-1];
      default: ;
    endcase
  end

  assign mag_a = sign_a ? -a : a;
  assign mag_b = sign_b ? -b : b;
  // Remainder follows the dividend; products and quotients follow a^b.
  assign neg_d = (op == OpRem) ? sign_a : (sign_a ^ sign_b);

`ifdef MDU_ITER_DIV_EN
  logic               div_zero, div_ovf;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_zero = op[2] & (b == '0);
  assign div_ovf  = ((op == OpDiv) | (op == OpRem)) & (a == MinVal) & (b == AllOnes);
  assign fast     = div_zero | div_ovf;

  // Restoring step: shift the next dividend bit into the remainder, keep the
  // difference only when it does not borrow.
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], lo_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], lo_q[WIDTH-2:0], 1'b1};
`else
  assign fast = op[2];
`endif

  // Shift-add step: conditionally add the multiplicand into the high half,
  // then shift the whole {carry, hi, lo} right by one.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, lo_q[WIDTH-1:1]};

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      cnt_q  <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
    end else if (accept) begin
      op_q   <= op;
      cnt_q  <= CNT_W'(WIDTH);
      opnd_q <= mag_b;
      hi_q   <= '0;
      lo_q   <= mag_a;
      neg_q  <= neg_d;
`ifdef MDU_ITER_DIV_EN
      if (div_zero) begin
        hi_q  <= a;
        lo_q  <= AllOnes;
        neg_q <= 1'b0;
      end else if (div_ovf) begin
        hi_q  <= '0;
        lo_q  <= MinVal;
        neg_q <= 1'b0;
      end
`else
      if (op[2]) begin
        hi_q  <= AllOnes;
        lo_q  <= AllOnes;
        neg_q <= 1'b0;
      end
`endif
    end else if (state_q == StBusy) begin
      cnt_q <= cnt_q - CNT_W'(1);
`ifdef MDU_ITER_DIV_EN
      if (op_q[2]) begin
        {hi_q, lo_q} <= div_next;
      end else begin
        {hi_q, lo_q} <= mul_next;
      end
`else
      {hi_q, lo_q} <= mul_next;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (accept) state_d = fast ? StDone : StBusy;
        StBusy: if (cnt_q == CNT_W'(1)) state_d = StDone;
        StDone: if (out_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs and result selection
  logic [2*WIDTH-1:0] prod_full;
  logic [WIDTH-1:0]   div_sel;

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    prod_full = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    div_sel   = op_q[1] ? hi_q : lo_q;
    result    = '0;
    if (out_valid) begin
      if (op_q[2]) begin
        result = neg_q ? -div_sel : div_sel;
      end else if (op_q == OpMul) begin
        result = prod_full[WIDTH-1:0];
      end else begin
        result = prod_full[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH = 32).
// Latency is counted in clock edges after the accept edge at which out_valid is first
// seen: 32 for iterative ops, 0 for ops that complete at the accept edge itself
// (visible in the cycle right after accept).
module tb_mdu_iter;

  localparam int unsigned W = 32;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Issue one request, scramble inputs after accept, then check latency, result,
  // optional stall with out_ready low, and the return to IDLE.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] want, input int lat,
                        input int hold);
    int edges;
    logic early_res;
    chk({tag, "/ready"}, 64'(in_ready), 64'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    edges = 0;
    early_res = 1'b0;
    while (!out_valid && edges < 200) begin
      if (result !== '0) early_res = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "/latency"}, 64'(edges), 64'(lat));
    chk({tag, "/result"}, 64'(result), 64'(want));
    chk({tag, "/zero_before_valid"}, 64'(early_res), 64'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "/hold_result"}, 64'(result), 64'(want));
      chk({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/post_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "/post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "/post_result"}, 64'(result), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog elapsed=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_valid;

    // Reset state
    #3;
    chk("reset/in_ready", 64'(in_ready), 64'd1);
    chk("reset/out_valid", 64'(out_valid), 64'd0);
    chk("reset/result", 64'(result), 64'd0);
    #9 rst_n = 1'b1;

    // Multiply, first one with a 5-cycle stall in DONE
    run_op("mul_m1x2", MUL, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32, 5);
    run_op("mulhu_m1x2", MULHU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32, 0);
    run_op("mulh_m1x2", MULH, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32, 0);
    run_op("mulhsu_m1x2", MULHSU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32, 0);
    run_op("mul_3x5", MUL, 32'd3, 32'd5, 32'd15, 32, 0);
    run_op("mulh_minxmin", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, 0);
    run_op("mul_minxmin", MUL, 32'h8000_0000, 32'h8000_0000, 32'h0, 32, 0);
    run_op("mulhu_maxxmax", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, 0);
    run_op("mulhsu_minxmax", MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32, 0);
    run_op("mul_m7x3", MUL, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFEB, 32, 0);

`ifdef MDU_ITER_DIV_EN
    run_op("div_m7d2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 0);
    run_op("rem_m7d2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 0);
    run_op("divu_100d7", DIVU, 32'd100, 32'd7, 32'd14, 32, 0);
    run_op("remu_100d7", REMU, 32'd100, 32'd7, 32'd2, 32, 0);
    run_op("divu_by0", DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 0, 0);
    run_op("remu_by0", REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 0, 0);
    run_op("div_by0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0);
    run_op("div_min_d2", DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 32, 0);
    run_op("rem_7_dm2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 32, 0);
    run_op("divu_max_d1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32, 0);
`else
    run_op("nodiv_div", DIV, 32'd100, 32'd7, 32'hFFFF_FFFF, 0, 0);
    run_op("nodiv_remu", REMU, 32'd100, 32'd7, 32'hFFFF_FFFF, 0, 0);
    run_op("nodiv_divu0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
`endif

    // Flush 10 cycles into BUSY with a competing request
    op = MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("flush/busy_in_ready", 64'(in_ready), 64'd0);
    chk("flush/busy_valid", 64'(out_valid), 64'd0);
    flush = 1'b1; in_valid = 1'b1; op = MUL; a = 32'd7; b = 32'd7;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush/idle_in_ready", 64'(in_ready), 64'd1);
    chk("flush/idle_valid", 64'(out_valid), 64'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("flush/no_result", 64'(saw_valid), 64'd0);
    chk("flush/still_idle", 64'(in_ready), 64'd1);

    // Reset pulse mid-BUSY, then accept at the first edge after release
    op = MUL; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy/in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy/out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy/result", 64'(result), 64'd0);
    #1 rst_n = 1'b1;
    run_op("post_rst_mul_3x5", MUL, 32'd3, 32'd5, 32'd15, 32, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
